coffee_order_fsm: RTL
=====================

// Module: coffee_order_fsm
// PURPOSE
//  Order-collection controller directly upstream of the price/change subtractor.
//  Latches the drink selection and accumulates inserted coins from front-panel buttons.
//  On user confirm, drives coffee_type/total_coins/confirm into the subtractor and samples
//  its enable/change result; sequences dispense, refund, cancel and inactivity timeout.
// PARAMETERS
//  MAX_COINS       15     saturation limit of the 4-bit coin total
//  DISPENSE_CYCLES 8      cycles dispense stays high after a successful purchase
//  TIMEOUT_CYCLES  1000   idle cycles in COLLECT before automatic refund
// PORTS
//  clk          in   1  single clock; all logic rising-edge
//  rst          in   1  synchronous, active-low reset
//  coin_btn     in   1  coin-insert button level; rising edge = one coin
//  coin_value   in   2  coin weight 1..3, sampled on coin_btn edge; 0 ignored
//  sel_btn      in   1  selection button level; rising edge latches coffee_sel
//  coffee_sel   in   3  drink code 1..4 (expresso, coffee&milk, capuccino, mocaccino)
//  confirm_btn  in   1  confirm button level; rising edge starts purchase check
//  cancel_btn   in   1  cancel button level; rising edge requests refund
//  sub_enable   in   1  subtractor "paid enough" result
//  sub_change   in   4  subtractor change result
//  coffee_type  out  3  latched drink code to subtractor
//  total_coins  out  4  coin total to subtractor
//  confirm      out  1  confirm strobe to subtractor
//  dispense     out  1  drink dispense active
//  change_out   out  4  change returned after purchase, held through DISPENSE
//  refund       out  4  refund amount, valid for one cycle on refund_valid
//  refund_valid out  1  one-cycle refund strobe
//  coin_reject  out  1  one-cycle pulse: coin refused (saturation / wrong state)
//  short_funds  out  1  one-cycle pulse: confirm with insufficient coins
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state=IDLE; every output 0; counters and edge regs cleared.
//  - All buttons go through rising-edge detect (registered prev value); action 1 cycle after edge.
//  - IDLE: sel edge with coffee_sel in 1..4 -> latch coffee_type, go COLLECT; 0,5..7 ignored.
//    Coin edges in IDLE -> coin_reject. Confirm/cancel ignored.
//  - COLLECT: coin edge with value v>0: if total+v<=MAX_COINS add, else total unchanged + coin_reject.
//    sel edge with valid code re-latches coffee_type (total kept).
//    Priority on the same cycle: cancel > confirm > coin > sel.
//    cancel edge -> REFUND. confirm edge -> CHECK. Timeout counter reset by any button edge;
//    reaching TIMEOUT_CYCLES-1 -> REFUND.
//  - CHECK (exactly 1 cycle): confirm=1; sub_enable/sub_change sampled at the end of the cycle.
//    enable=1 -> change_out<=sub_change, go DISPENSE; enable=0 -> short_funds pulse, back to COLLECT.
//  - DISPENSE: dispense=1 for DISPENSE_CYCLES cycles; all buttons ignored. Then DONE.
//  - DONE (1 cycle): clear total, coffee_type, change_out -> IDLE.
//  - REFUND (1 cycle): refund=total, refund_valid=1; clear total and coffee_type -> IDLE.
//    total=0 still produces refund_valid with refund=0.
//  - confirm is high only in CHECK; coffee_type/total_coins are held stable in CHECK.
//  - Reset mid-DISPENSE or mid-REFUND aborts immediately to IDLE; no refund is emitted.
// STRUCTURE
//  - coffee_pkg: state_t enum (IDLE, COLLECT, CHECK, DISPENSE, DONE, REFUND), drink code
//    localparams, PRICE_* constants (3,4,5,7) for bench reference.
//  - Sub-module btn_edge (registered rising-edge detect, sync active-low reset), one per button.
//  - Single FSM plus total, dispense and timeout counters in this module.
// TESTING
//  1. sel=3; coins 2,2,1 (total 5); confirm; subtractor model -> confirm 1 cycle,
//     enable=1, change_out=0, dispense high 8 cycles, then all outputs 0.
//  2. sel=4; coins 3,3 (total 6); confirm -> short_funds pulse, state COLLECT, total 6;
//     coin 1, confirm -> dispense.
//  3. sel=1; coins 3x5 (15); coin 1 -> coin_reject, total stays 15; confirm -> change_out=12.
//  4. sel=2; coins 3,1; cancel -> refund_valid 1 cycle, refund=4; then IDLE, total 0.
//  5. sel=2; coin 2; no activity for TIMEOUT_CYCLES -> refund=2; coin_btn in IDLE -> coin_reject.
//  6. Cancel and confirm edges on the same cycle -> refund wins.
//     rst=0 during DISPENSE -> next cycle dispense=0, state IDLE.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee order controller and its bench.
package coffee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        DISPENSE,
        DONE,
        REFUND
    } state_t;

    localparam logic [2:0] DRINK_EXPRESSO    = 3'd1;
    localparam logic [2:0] DRINK_COFFEE_MILK = 3'd2;
    localparam logic [2:0] DRINK_CAPUCCINO   = 3'd3;
    localparam logic [2:0] DRINK_MOCACCINO   = 3'd4;

    localparam int PRICE_EXPRESSO    = 3;
    localparam int PRICE_COFFEE_MILK = 4;
    localparam int PRICE_CAPUCCINO   = 5;
    localparam int PRICE_MOCACCINO   = 7;

    function automatic logic is_valid_drink(input logic [2:0] code);
        return (code >= DRINK_EXPRESSO) && (code <= DRINK_MOCACCINO);
    endfunction

endpackage

// File: rtl/coffee_order_fsm_if.sv
// Front-panel buttons, subtractor handshake and user-facing results of the order controller.
interface coffee_order_fsm_if;

    logic       coin_btn;
    logic [1:0] coin_value;
    logic       sel_btn;
    logic [2:0] coffee_sel;
    logic       confirm_btn;
    logic       cancel_btn;
    logic       sub_enable;
    logic [3:0] sub_change;
    logic [2:0] coffee_type;
    logic [3:0] total_coins;
    logic       confirm;
    logic       dispense;
    logic [3:0] change_out;
    logic [3:0] refund;
    logic       refund_valid;
    logic       coin_reject;
    logic       short_funds;

    // master: the panel plus subtractor side; slave: the order controller
    modport master (
        output coin_btn, coin_value, sel_btn, coffee_sel, confirm_btn, cancel_btn,
               sub_enable, sub_change,
        input  coffee_type, total_coins, confirm, dispense, change_out, refund,
               refund_valid, coin_reject, short_funds
    );

    modport slave (
        input  coin_btn, coin_value, sel_btn, coffee_sel, confirm_btn, cancel_btn,
               sub_enable, sub_change,
        output coffee_type, total_coins, confirm, dispense, change_out, refund,
               refund_valid, coin_reject, short_funds
    );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a button level; the previous level is registered.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) prev <= 1'b0;
        else      prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/coffee_order_fsm.sv
// Order-collection controller: latches drink and coins, consults the subtractor on confirm,
// then sequences dispense, refund, cancel and inactivity timeout.
module coffee_order_fsm
    import coffee_pkg::*;
#(
    parameter int MAX_COINS       = 15,
    parameter int DISPENSE_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    coffee_order_fsm_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DISPENSE_LAST = DW'(DISPENSE_CYCLES - 1);

    logic coin_rise, sel_rise, confirm_rise, cancel_rise, any_rise;

    btn_edge u_coin    (.clk(clk), .rst(rst), .btn(bus.coin_btn),    .rise(coin_rise));
    btn_edge u_sel     (.clk(clk), .rst(rst), .btn(bus.sel_btn),     .rise(sel_rise));
    btn_edge u_confirm (.clk(clk), .rst(rst), .btn(bus.confirm_btn), .rise(confirm_rise));
    btn_edge u_cancel  (.clk(clk), .rst(rst), .btn(bus.cancel_btn),  .rise(cancel_rise));

    assign any_rise = coin_rise | sel_rise | confirm_rise | cancel_rise;

    state_t        state;
    logic [2:0]    coffee_type;
    logic [3:0]    total;
    logic          confirm, dispense, refund_valid, coin_reject, short_funds;
    logic [3:0]    change_out, refund;
    logic [TW-1:0] timeout_cnt;
    logic [DW-1:0] dispense_cnt;
    logic [4:0]    coin_sum;

    // One bit wider so a saturating overflow is visible before it is committed.
    assign coin_sum = {1'b0, total} + {3'b000, bus.coin_value};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            coffee_type  <= '0;
            total        <= '0;
            confirm      <= 1'b0;
            dispense     <= 1'b0;
            change_out   <= '0;
            refund       <= '0;
            refund_valid <= 1'b0;
            coin_reject  <= 1'b0;
            short_funds  <= 1'b0;
            timeout_cnt  <= '0;
            dispense_cnt <= '0;
        end else begin
            // Strobes default low here and are raised below only on the cycle they fire.
            coin_reject  <= 1'b0;
            short_funds  <= 1'b0;
            refund_valid <= 1'b0;
            refund       <= '0;

            case (state)
                IDLE: begin
                    if (coin_rise && bus.coin_value != 2'd0) coin_reject <= 1'b1;
                    if (sel_rise && is_valid_drink(bus.coffee_sel)) begin
                        coffee_type <= bus.coffee_sel;
                        timeout_cnt <= '0;
                        state       <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (any_rise) timeout_cnt <= '0;
                    if (cancel_rise) begin
                        state <= REFUND;
                    end else if (confirm_rise) begin
                        confirm <= 1'b1;
                        state   <= CHECK;
                    end else if (coin_rise) begin
                        if (bus.coin_value != 2'd0) begin
                            if (coin_sum <= 5'(MAX_COINS)) total <= coin_sum[3:0];
                            else                           coin_reject <= 1'b1;
                        end
                    end else if (sel_rise) begin
                        if (is_valid_drink(bus.coffee_sel)) coffee_type <= bus.coffee_sel;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state <= REFUND;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    confirm <= 1'b0;
                    if (bus.sub_enable) begin
                        change_out   <= bus.sub_change;
                        dispense     <= 1'b1;
                        dispense_cnt <= '0;
                        state        <= DISPENSE;
                    end else begin
                        short_funds <= 1'b1;
                        timeout_cnt <= '0;
                        state       <= COLLECT;
                    end
                end

                DISPENSE: begin
                    if (dispense_cnt == DISPENSE_LAST) begin
                        dispense <= 1'b0;
                        state    <= DONE;
                    end else begin
                        dispense_cnt <= dispense_cnt + 1'b1;
                    end
                end

                DONE: begin
                    total       <= '0;
                    coffee_type <= '0;
                    change_out  <= '0;
                    state       <= IDLE;
                end

                REFUND: begin
                    // Strobe is emitted on leaving REFUND so a reset taken here suppresses it.
                    refund       <= total;
                    refund_valid <= 1'b1;
                    total        <= '0;
                    coffee_type  <= '0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.coffee_type  = coffee_type;
    assign bus.total_coins  = total;
    assign bus.confirm      = confirm;
    assign bus.dispense     = dispense;
    assign bus.change_out   = change_out;
    assign bus.refund       = refund;
    assign bus.refund_valid = refund_valid;
    assign bus.coin_reject  = coin_reject;
    assign bus.short_funds  = short_funds;

endmodule
